tx_link_scheduler: RTL and testbench
====================================

Name: tx_link_scheduler

Overview:
- Byte-level transmit scheduler that feeds the 8-bit lane mux/demux datapath.
- Arbitrates between two packet requesters: transaction packets (TLP), framed STP..END, and link packets (DLLP), framed SDP..END.
- Inserts periodic skip ordered sets (COM + SKP_COUNT x SKP) at packet boundaries only.
- Drives IDL when nothing is pending. Runs on the byte clock clk_1m.

Parameters:
- SKP_INTERVAL, 16, clk_1m cycles between skip-ordered-set requests (min 8).
- SKP_COUNT, 3, number of SKP symbols following each COM (1..7).
- CNT_W, 8, width of the skip interval counter (must hold SKP_INTERVAL-1).

Ports:
- clk_1m  in  1  byte clock; all state changes on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- link_en  in  1  1 = scheduling enabled; 0 = finish current item, then hold in IDLE with out_valid=0.
- tlp_valid  in  1  TLP source has a byte on tlp_data.
- tlp_data  in  8  TLP payload byte.
- tlp_last  in  1  current TLP byte is the final payload byte.
- tlp_ready  out  1  combinational; byte accepted when tlp_valid & tlp_ready.
- dllp_valid, dllp_data[7:0], dllp_last, dllp_ready: same as the TLP set, for DLLP.
- out_data  out  8  registered symbol to the mux.
- out_k  out  1  registered; 1 = out_data is a control symbol.
- out_valid  out  1  registered symbol-valid.
- skp_pending  out  1  registered status; skip ordered set is owed.

Behaviour:
- Symbols: COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C.
- Reset (async, reset_L=0):
  - Outputs: out_data=IDL, out_k=1, out_valid=0, skp_pending=0.
  - State: state=IDLE, skp counter=0, skp_sent=0, last_grant=DLLP (so TLP wins the first tie).
  - Readies are 0 while reset_L is low.
- Skip timer:
  - Counter increments every cycle.
  - When the counter equals SKP_INTERVAL-1, it wraps to 0 and sets skp_pending.
  - skp_pending clears on the edge that registers COM. If a wrap coincides with that edge, set wins.
- Latency: every output symbol is registered, so one cycle from decision or acceptance to out_*.
- FSM states: IDLE, SOS, BODY, ENDS.
- IDLE (evaluated every cycle; priority order):
  1. skp_pending & link_en: emit COM, go SOS.
  2. Otherwise, a valid source & link_en: emit STP (TLP) or SDP (DLLP), record owner, go BODY.
     - Both valid: grant the source not equal to last_grant; update last_grant.
  3. Otherwise: emit IDL with out_valid = link_en.
  - Start symbol does not consume a source byte (ready=0 in IDLE).
- SOS: emit SKP each cycle while counting skp_sent. After SKP_COUNT SKPs, return to IDLE and clear skp_sent.
- BODY:
  - Owner's ready=1; the other ready=0.
  - On valid&ready: emit byte with out_k=0, out_valid=1.
  - On a transfer with last=1, go ENDS.
  - Owner valid=0 (underflow): out_valid=0 that cycle, state held, no symbol emitted.
- ENDS: emit END (k=1), go IDLE. The next item's start symbol can appear the following cycle, with no IDL gap.
- Boundaries:
  - Skip never interrupts BODY. A pending skip is served at the next IDLE, ahead of all waiting packets.
  - Single-byte packet (last on first byte): STP, b0, END.
  - link_en falling mid-packet does not abort the packet.
  - Reset mid-packet abandons the packet; sources must restart framing.
  - A source dropping valid while not granted has no effect.

Decomposition:
- Shared package link_symbols_pkg holds:
  - Symbol localparams COM/SKP/STP/SDP/END/IDL.
  - FSM state encoding (2 bits).
  - Owner encoding (TLP=0, DLLP=1).
- One natural sub-module, skp_timer: counter, wrap detect, pending flag with set-over-clear.
- Arbitration and FSM remain in tx_link_scheduler.

Test Plan:
- Edge numbering: edge n is the nth clk_1m rising edge after reset_L rises.
- Idle skip: link_en=1, no traffic, SKP_INTERVAL=16.
  - out IDL,valid until edge 17 registers COM; edges 18,19,20 register SKP.
  - Edge 21: IDL; skp_pending=0 after edge 17.
- Single TLP: bytes 8'h11,8'h22,8'h33 (last on 33) → out STP(k1), 11,22,33 (k0), END(k1), then IDL.
  - tlp_ready high only in BODY.
- Tie round-robin: TLP and DLLP both valid at reset release.
  - STP-TLP packet first, END, then SDP-DLLP packet immediately after END with no IDL.
  - Repeat tie: TLP granted again.
- Skip during packet: skp_pending rises mid-BODY of a 20-byte TLP.
  - Packet completes unbroken, END, then COM+3xSKP before the waiting DLLP's SDP.
- Underflow/stall: tlp_valid deasserted for 2 cycles mid-BODY.
  - out_valid=0 for exactly 2 cycles, no bytes lost or duplicated.
- Async reset mid-BODY: reset_L low between edges.
  - out_valid=0, out_k=1, out_data=IDL, and both readies=0 immediately.
  - After release, state IDLE and timer restarted.

Source files
------------

// File: rtl/link_symbols_pkg.sv
// Shared symbol codes, FSM state encoding and source-owner encoding for the
// transmit link scheduler.
package link_symbols_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] IDL = 8'h7C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOS  = 2'd1,
        ST_BODY = 2'd2,
        ST_ENDS = 2'd3
    } link_state_e;

    typedef enum logic {
        OWN_TLP  = 1'b0,
        OWN_DLLP = 1'b1
    } owner_e;

    // A tie goes to whichever source was not granted last.
    function automatic owner_e rr_pick(input logic tlp_v, input logic dllp_v,
                                       input owner_e last_grant);
        if (tlp_v && dllp_v) begin
            return (last_grant == OWN_TLP) ? OWN_DLLP : OWN_TLP;
        end
        return dllp_v ? OWN_DLLP : OWN_TLP;
    endfunction

endpackage

// File: rtl/tx_link_scheduler_if.sv
// Source handshakes (TLP, DLLP) and the registered symbol stream towards the
// lane mux. master = scheduler side, slave = sources/mux side.
interface tx_link_scheduler_if;

    logic       tlp_valid;
    logic [7:0] tlp_data;
    logic       tlp_last;
    logic       tlp_ready;

    logic       dllp_valid;
    logic [7:0] dllp_data;
    logic       dllp_last;
    logic       dllp_ready;

    logic [7:0] out_data;
    logic       out_k;
    logic       out_valid;
    logic       skp_pending;

    modport master (
        input  tlp_valid, tlp_data, tlp_last,
        input  dllp_valid, dllp_data, dllp_last,
        output tlp_ready, dllp_ready,
        output out_data, out_k, out_valid, skp_pending
    );

    modport slave (
        output tlp_valid, tlp_data, tlp_last,
        output dllp_valid, dllp_data, dllp_last,
        input  tlp_ready, dllp_ready,
        input  out_data, out_k, out_valid, skp_pending
    );

endinterface

// File: rtl/skp_timer.sv
// Free-running skip interval timer; raises a pending flag on every wrap and
// drops it when the scheduler registers COM (a coincident wrap wins).
module skp_timer #(
    parameter int SKP_INTERVAL = 16,
    parameter int CNT_W        = 8
) (
    input  logic clk_1m,
    input  logic reset_L,
    input  logic com_sent_i,
    output logic skp_pending_o
);

    localparam logic [CNT_W-1:0] WRAP_AT = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pend_q;
    logic             pend_d;
    logic             wrap;

    always_comb begin
        wrap   = (cnt_q == WRAP_AT);
        cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
        pend_d = pend_q;
        if (com_sent_i) begin
            pend_d = 1'b0;
        end
        if (wrap) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1m or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign skp_pending_o = pend_q;

endmodule

// File: rtl/tx_link_scheduler.sv
// Byte-level transmit scheduler: frames TLP/DLLP packets, round-robins ties,
// and slots skip ordered sets in at packet boundaries.
//
//   state | meaning
//   IDLE  | between items: serve owed skip, else start a packet, else IDL
//   SOS   | emitting the SKP symbols that follow a COM
//   BODY  | forwarding the owner's payload bytes
//   ENDS  | emitting END after the last payload byte
module tx_link_scheduler
    import link_symbols_pkg::*;
#(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_COUNT    = 3,
    parameter int CNT_W        = 8
) (
    input  logic                  clk_1m,
    input  logic                  reset_L,
    input  logic                  link_en,
    tx_link_scheduler_if.master   lnk
);

    localparam logic [2:0] SKP_LAST = 3'(SKP_COUNT - 1);

    link_state_e state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_grant_q, last_grant_d;
    owner_e      pick;
    logic [2:0]  skp_sent_q, skp_sent_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_k_q, out_k_d;
    logic        out_valid_q, out_valid_d;

    logic        skp_pending;
    logic        com_sent;
    logic        any_valid;
    logic        own_valid;
    logic        own_last;
    logic [7:0]  own_data;

    skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_timer (
        .clk_1m        (clk_1m),
        .reset_L       (reset_L),
        .com_sent_i    (com_sent),
        .skp_pending_o (skp_pending)
    );

    always_comb begin
        any_valid = lnk.tlp_valid | lnk.dllp_valid;
        pick      = rr_pick(lnk.tlp_valid, lnk.dllp_valid, last_grant_q);
        if (owner_q == OWN_DLLP) begin
            own_valid = lnk.dllp_valid;
            own_last  = lnk.dllp_last;
            own_data  = lnk.dllp_data;
        end else begin
            own_valid = lnk.tlp_valid;
            own_last  = lnk.tlp_last;
            own_data  = lnk.tlp_data;
        end
    end

    // Readies follow the state register alone, so reset drops them at once.
    assign lnk.tlp_ready  = (state_q == ST_BODY) && (owner_q == OWN_TLP);
    assign lnk.dllp_ready = (state_q == ST_BODY) && (owner_q == OWN_DLLP);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        skp_sent_d   = skp_sent_q;
        out_data_d   = IDL;
        out_k_d      = 1'b1;
        out_valid_d  = 1'b0;
        com_sent     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (skp_pending && link_en) begin
                    out_data_d  = COM;
                    out_valid_d = 1'b1;
                    com_sent    = 1'b1;
                    state_d     = ST_SOS;
                end else if (link_en && any_valid) begin
                    owner_d      = pick;
                    last_grant_d = pick;
                    out_data_d   = (pick == OWN_DLLP) ? SDP : STP;
                    out_valid_d  = 1'b1;
                    state_d      = ST_BODY;
                end else begin
                    out_valid_d = link_en;
                end
            end
            ST_SOS: begin
                out_data_d  = SKP;
                out_valid_d = 1'b1;
                if (skp_sent_q == SKP_LAST) begin
                    skp_sent_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    skp_sent_d = skp_sent_q + 3'd1;
                end
            end
            ST_BODY: begin
                // An owner underflow simply emits nothing and holds position.
                if (own_valid) begin
                    out_data_d  = own_data;
                    out_k_d     = 1'b0;
                    out_valid_d = 1'b1;
                    if (own_last) begin
                        state_d = ST_ENDS;
                    end
                end
            end
            ST_ENDS: begin
                out_data_d  = END;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1m or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_TLP;
            last_grant_q <= OWN_DLLP;
            skp_sent_q   <= '0;
            out_data_q   <= IDL;
            out_k_q      <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            skp_sent_q   <= skp_sent_d;
            out_data_q   <= out_data_d;
            out_k_q      <= out_k_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign lnk.out_data    = out_data_q;
    assign lnk.out_k       = out_k_q;
    assign lnk.out_valid   = out_valid_q;
    assign lnk.skp_pending = skp_pending;

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed and randomized bench for tx_link_scheduler; an item-level reference
// model predicts every registered symbol, the pending flag and both readies.
module tb_tx_link_scheduler;

    localparam int SKP_INTERVAL = 16;
    localparam int SKP_COUNT    = 3;

    localparam logic [7:0] S_COM = 8'hBC;
    localparam logic [7:0] S_SKP = 8'h1C;
    localparam logic [7:0] S_STP = 8'hFB;
    localparam logic [7:0] S_SDP = 8'h5C;
    localparam logic [7:0] S_END = 8'hFD;
    localparam logic [7:0] S_IDL = 8'h7C;

    localparam int M_GAP  = 0;
    localparam int M_SKIP = 1;
    localparam int M_PKT  = 2;
    localparam int M_TAIL = 3;

    logic clk_1m  = 1'b0;
    logic reset_L = 1'b1;
    logic link_en = 1'b0;

    tx_link_scheduler_if lnk ();

    tx_link_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_COUNT    (SKP_COUNT),
        .CNT_W        (8)
    ) dut (
        .clk_1m  (clk_1m),
        .reset_L (reset_L),
        .link_en (link_en),
        .lnk     (lnk)
    );

    always #5 clk_1m = ~clk_1m;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    logic [8:0] drv_q [2][$];
    logic [8:0] mdl_q [2][$];
    logic [9:0] olog [$];
    logic [9:0] xq [$];
    int         gap_pct [2];
    logic       hold [2];

    int   m_phase;
    int   m_own;
    int   m_last;
    int   m_skp;
    logic m_pend;

    function automatic logic [9:0] K(input logic [7:0] s);
        return {2'b11, s};
    endfunction

    function automatic logic [9:0] D(input logic [7:0] b);
        return {2'b10, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic chk_log(input string tag, input int first);
        for (int i = 0; i < xq.size(); i++) begin
            chk(tag, olog[first - 1 + i], xq[i]);
        end
        xq.delete();
    endtask

    task automatic add_pkt(input int s, input int len, input bit rnd, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(base + 8'(i * 17));
            drv_q[s].push_back({(i == len - 1), b});
            mdl_q[s].push_back({(i == len - 1), b});
        end
    endtask

    task automatic drive();
        logic v [2];
        for (int s = 0; s < 2; s++) begin
            v[s] = (drv_q[s].size() > 0) && !hold[s] && ($urandom_range(99) >= gap_pct[s]);
        end
        lnk.tlp_valid  = v[0];
        lnk.tlp_data   = 8'h00;
        lnk.tlp_last   = 1'b0;
        lnk.dllp_valid = v[1];
        lnk.dllp_data  = 8'h00;
        lnk.dllp_last  = 1'b0;
        if (v[0]) begin
            lnk.tlp_data = drv_q[0][0][7:0];
            lnk.tlp_last = drv_q[0][0][8];
        end
        if (v[1]) begin
            lnk.dllp_data = drv_q[1][0][7:0];
            lnk.dllp_last = drv_q[1][0][8];
        end
    endtask

    // Predicts the symbol registered on this edge from the source state seen
    // during the preceding cycle.
    task automatic model_edge(input logic tv, input logic dv, input logic len);
        logic [9:0] exp;
        logic [8:0] b;
        logic       pend_b;
        pend_b = m_pend;
        exp    = 10'h000;
        case (m_phase)
            M_GAP: begin
                if (pend_b && len) begin
                    exp     = K(S_COM);
                    m_skp   = 0;
                    m_phase = M_SKIP;
                end else if (len && (tv || dv)) begin
                    m_own   = (tv && dv) ? 1 - m_last : (dv ? 1 : 0);
                    m_last  = m_own;
                    exp     = K((m_own == 1) ? S_SDP : S_STP);
                    m_phase = M_PKT;
                end else if (len) begin
                    exp = K(S_IDL);
                end
            end
            M_SKIP: begin
                exp = K(S_SKP);
                m_skp++;
                if (m_skp == SKP_COUNT) m_phase = M_GAP;
            end
            M_PKT: begin
                if ((m_own == 1) ? dv : tv) begin
                    if (mdl_q[m_own].size() == 0) begin
                        exp = 10'h3FF;
                    end else begin
                        b   = mdl_q[m_own].pop_front();
                        exp = D(b[7:0]);
                        if (b[8]) m_phase = M_TAIL;
                    end
                end
            end
            default: begin
                exp     = K(S_END);
                m_phase = M_GAP;
            end
        endcase
        if (edge_n % SKP_INTERVAL == 0) m_pend = 1'b1;
        else if (exp == K(S_COM)) m_pend = 1'b0;
        chk("symbol", olog[$], exp);
        chk("skp_pending", lnk.skp_pending, m_pend);
    endtask

    task automatic step();
        logic tv, dv, len, ft, fd;
        @(negedge clk_1m);
        tv  = lnk.tlp_valid;
        dv  = lnk.dllp_valid;
        len = link_en;
        chk("tlp_ready", lnk.tlp_ready, (m_phase == M_PKT) && (m_own == 0));
        chk("dllp_ready", lnk.dllp_ready, (m_phase == M_PKT) && (m_own == 1));
        ft = tv && lnk.tlp_ready;
        fd = dv && lnk.dllp_ready;
        @(posedge clk_1m);
        #1;
        edge_n++;
        olog.push_back(lnk.out_valid ? {1'b1, lnk.out_k, lnk.out_data} : 10'h000);
        model_edge(tv, dv, len);
        if (ft) void'(drv_q[0].pop_front());
        if (fd) void'(drv_q[1].pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk("rst_out_data", lnk.out_data, S_IDL);
        chk("rst_out_k", lnk.out_k, 1'b1);
        chk("rst_out_valid", lnk.out_valid, 1'b0);
        chk("rst_skp_pending", lnk.skp_pending, 1'b0);
        chk("rst_tlp_ready", lnk.tlp_ready, 1'b0);
        chk("rst_dllp_ready", lnk.dllp_ready, 1'b0);
        for (int s = 0; s < 2; s++) begin
            drv_q[s].delete();
            mdl_q[s].delete();
            hold[s]    = 1'b0;
            gap_pct[s] = 0;
        end
        olog.delete();
        m_phase = M_GAP;
        m_own   = 0;
        m_last  = 1;
        m_skp   = 0;
        m_pend  = 1'b0;
        edge_n  = 0;
        drive();
        repeat (2) @(posedge clk_1m);
        #1 reset_L = 1'b1;
    endtask

    initial begin
        bit done;
        #2 do_reset();

        // idle link: COM on edge 17, three SKPs, then IDL again
        link_en = 1'b1;
        drive();
        repeat (21) step();
        xq = '{K(S_IDL)};
        chk_log("idle_first", 1);
        xq = '{K(S_IDL), K(S_COM), K(S_SKP), K(S_SKP), K(S_SKP), K(S_IDL)};
        chk_log("idle_skip", 16);

        // single three-byte TLP
        do_reset();
        link_en = 1'b1;
        add_pkt(0, 3, 1'b0, 8'h11);
        drive();
        repeat (6) step();
        xq = '{K(S_STP), D(8'h11), D(8'h22), D(8'h33), K(S_END), K(S_IDL)};
        chk_log("single_tlp", 1);

        // both sources valid from reset release: alternating grants, no IDL gaps
        do_reset();
        link_en = 1'b1;
        add_pkt(0, 2, 1'b0, 8'hA1);
        add_pkt(1, 1, 1'b0, 8'hB1);
        add_pkt(0, 1, 1'b0, 8'hC1);
        add_pkt(1, 1, 1'b0, 8'hD1);
        drive();
        repeat (14) step();
        xq = '{K(S_STP), D(8'hA1), D(8'hB2), K(S_END), K(S_SDP), D(8'hB1), K(S_END),
               K(S_STP), D(8'hC1), K(S_END), K(S_SDP), D(8'hD1), K(S_END), K(S_IDL)};
        chk_log("tie_rr", 1);

        // skip owed mid-packet is served after END, ahead of the waiting DLLP
        do_reset();
        link_en = 1'b1;
        add_pkt(0, 20, 1'b0, 8'h01);
        add_pkt(1, 1, 1'b0, 8'h5A);
        drive();
        repeat (30) step();
        xq = '{D(8'h44), K(S_END), K(S_COM), K(S_SKP), K(S_SKP), K(S_SKP),
               K(S_SDP), D(8'h5A), K(S_END), K(S_IDL)};
        chk_log("skip_after_pkt", 21);

        // two-cycle source underflow inside the body
        do_reset();
        link_en = 1'b1;
        add_pkt(0, 5, 1'b0, 8'h30);
        drive();
        repeat (3) step();
        hold[0] = 1'b1;
        drive();
        repeat (2) step();
        hold[0] = 1'b0;
        drive();
        repeat (5) step();
        xq = '{K(S_STP), D(8'h30), D(8'h41), 10'h000, 10'h000, D(8'h52), D(8'h63),
               D(8'h74), K(S_END), K(S_IDL)};
        chk_log("underflow", 1);

        // asynchronous reset in the middle of a body, then timer restart
        do_reset();
        link_en = 1'b1;
        add_pkt(0, 10, 1'b0, 8'h00);
        drive();
        repeat (4) step();
        do_reset();
        link_en = 1'b1;
        drive();
        repeat (17) step();
        xq = '{K(S_IDL)};
        chk_log("rst_restart_idle", 1);
        xq = '{K(S_COM)};
        chk_log("rst_restart_com", 17);

        // randomized traffic with source gaps and link_en toggling
        do_reset();
        link_en    = 1'b1;
        gap_pct[0] = 25;
        gap_pct[1] = 25;
        drive();
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (drv_q[s].size() == 0 && $urandom_range(3) == 0) begin
                    add_pkt(s, $urandom_range(1, 6), 1'b1, 8'h00);
                end
            end
            if ($urandom_range(19) == 0) link_en = ~link_en;
            drive();
            step();
        end

        link_en    = 1'b1;
        gap_pct[0] = 0;
        gap_pct[1] = 0;
        drive();
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            step();
            done = (mdl_q[0].size() == 0) && (mdl_q[1].size() == 0) && (m_phase == M_GAP);
        end
        chk("drain_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
